// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoding constants: instruction classes, major opcodes and
// the loader FSM state encoding.
package rv_isa_pkg;

    localparam logic [3:0] CLS_R       = 4'd0;
    localparam logic [3:0] CLS_I_ARITH = 4'd1;
    localparam logic [3:0] CLS_I_SHIFT = 4'd2;
    localparam logic [3:0] CLS_LOAD    = 4'd3;
    localparam logic [3:0] CLS_STORE   = 4'd4;
    localparam logic [3:0] CLS_BRANCH  = 4'd5;
    localparam logic [3:0] CLS_JAL     = 4'd6;
    localparam logic [3:0] CLS_JALR    = 4'd7;
    localparam logic [3:0] CLS_LUI     = 4'd8;
    localparam logic [3:0] CLS_AUIPC   = 4'd9;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_e;

    // funct7 as used by R-type and shift-immediate: only bit 30 is variable.
    function automatic logic [6:0] funct7_of(input logic f7b5);
        return {1'b0, f7b5, 5'b00000};
    endfunction

endpackage

// File: rtl/rv_field_packer.sv
// Combinational packer: instruction class plus decoded fields to a 32-bit
// RV32I word, with illegal-class and odd-branch-target flags.
module rv_field_packer
    import rv_isa_pkg::*;
(
    input  logic [3:0]  cls_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o,
    output logic        misalign_o
);

    // Upper immediate bits beyond every field are dropped on purpose.
    logic unused_imm_s;
    assign unused_imm_s = ^imm_i[31:21];

    // Field placement per class; unused fields stay zero.
    always_comb begin
        word_o     = 32'd0;
        illegal_o  = 1'b0;
        misalign_o = 1'b0;
        case (cls_i)
            CLS_R:       word_o = {funct7_of(funct7b5_i), rs2_i, rs1_i, funct3_i, rd_i, OP_R};
            CLS_I_ARITH: word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_I};
            CLS_I_SHIFT: word_o = {funct7_of(funct7b5_i), imm_i[4:0], rs1_i, funct3_i, rd_i, OP_I};
            CLS_LOAD:    word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LOAD};
            CLS_STORE:   word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_STORE};
            CLS_BRANCH: begin
                word_o     = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                              imm_i[4:1], imm_i[11], OP_BRANCH};
                misalign_o = imm_i[0];
            end
            CLS_JAL: begin
                word_o     = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
                misalign_o = imm_i[0];
            end
            CLS_JALR:    word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_JALR};
            CLS_LUI:     word_o = {imm_i[19:0], rd_i, OP_LUI};
            CLS_AUIPC:   word_o = {imm_i[19:0], rd_i, OP_AUIPC};
            default:     illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Session-based instruction loader: encodes streamed field records and writes
// the words to consecutive instruction-memory addresses.
module instr_encoder_loader
    import rv_isa_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] count,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_class,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic [31:0]      imm,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic             busy,
    output logic             done,
    output logic             err_illegal,
    output logic             err_align
);

    load_state_e      state_q, state_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [31:0]      addr_q, addr_d;
    logic             we_q, we_d;
    logic [31:0]      waddr_q, waddr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             ill_q, ill_d;
    logic             aln_q, aln_d;

    logic [31:0]      pk_word_s;
    logic             pk_illegal_s;
    logic             pk_misalign_s;
    logic             unused_base_s;

    assign unused_base_s = ^base_addr[1:0];

    rv_field_packer u_packer (
        .cls_i      (in_class),
        .rd_i       (rd),
        .rs1_i      (rs1),
        .rs2_i      (rs2),
        .funct3_i   (funct3),
        .funct7b5_i (funct7b5),
        .imm_i      (imm),
        .word_o     (pk_word_s),
        .illegal_o  (pk_illegal_s),
        .misalign_o (pk_misalign_s)
    );

    // Session FSM, remaining-count/address counters and write-port next state.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        addr_d   = addr_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        ill_d    = ill_q;
        aln_d    = aln_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d   = {base_addr[31:2], 2'b00};
                    remain_d = count;
                    ill_d    = 1'b0;
                    aln_d    = 1'b0;
                    state_d  = (count == {CNT_W{1'b0}}) ? ST_DONE : ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    remain_d = remain_q - CNT_W'(1);
                    // Illegal records consume a count slot but leave memory and address untouched.
                    if (pk_illegal_s) begin
                        ill_d = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = pk_word_s;
                        addr_d  = addr_q + 32'd4;
                        aln_d   = aln_q | pk_misalign_s;
                    end
                    state_d = (remain_q == CNT_W'(1)) ? ST_DONE : ST_LOAD;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            remain_q <= {CNT_W{1'b0}};
            addr_q   <= 32'd0;
            we_q     <= 1'b0;
            waddr_q  <= 32'd0;
            wdata_q  <= 32'd0;
            ill_q    <= 1'b0;
            aln_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            ill_q    <= ill_d;
            aln_q    <= aln_d;
        end
    end

    assign in_ready    = (state_q == ST_LOAD);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign imem_we     = we_q;
    assign imem_addr   = waddr_q;
    assign imem_wdata  = wdata_q;
    assign err_illegal = ill_q;
    assign err_align   = aln_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Testbench for instr_encoder_loader: encoding vector table plus session,
// error-flag and reset-abort sequences, writes checked through a scoreboard.
module tb_instr_encoder_loader;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      base_addr = 32'd0;
    logic [CNT_W-1:0] count = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       in_class = 4'd0;
    logic [4:0]       rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
    logic [2:0]       funct3 = 3'd0;
    logic             funct7b5 = 1'b0;
    logic [31:0]      imm = 32'd0;
    logic             imem_we;
    logic [31:0]      imem_addr, imem_wdata;
    logic             busy, done, err_illegal, err_align;

    instr_encoder_loader #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
        .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class), .rd(rd),
        .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7b5(funct7b5), .imm(imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err_illegal(err_illegal), .err_align(err_align)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        f7b5;
        logic [31:0] imm;
        logic [31:0] word;
        logic        ill;
        logic        aln;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    vec_t        vecs[16];
    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          first_wr = -1;
    int          last_wr = -1;
    logic [31:0] exp_addr = 32'd0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: every write must match the oldest expected entry.
    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (rst_n && imem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual addr=0x%08h data=0x%08h expected no write",
                         imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                check32("wr_addr", imem_addr, e.addr);
                check32("wr_data", imem_wdata, e.data);
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
            end
        end
    end

    task automatic open_session(input logic [31:0] base, input logic [CNT_W-1:0] n);
        start     = 1'b1;
        base_addr = base;
        count     = n;
        exp_addr  = {base[31:2], 2'b00};
        first_wr  = -1;
        last_wr   = -1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input vec_t v);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_class = v.cls;
        rd       = v.rd;
        rs1      = v.rs1;
        rs2      = v.rs2;
        funct3   = v.f3;
        funct7b5 = v.f7b5;
        imm      = v.imm;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual in_ready=0 expected 1");
        end else if (!v.ill) begin
            exp_q.push_back('{exp_addr, v.word});
            exp_addr += 32'd4;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Waits for the done pulse; returns the negedges waited and the flags seen with it.
    task automatic wait_done(input string name, output int lat, output logic ill, output logic aln);
        lat = 0;
        @(negedge clk);
        while (!done && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        ill = err_illegal;
        aln = err_align;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_done_timeout actual done=0 expected 1", name);
        end
        @(negedge clk);
        check32({name, "_done_width"}, {31'd0, done}, 32'd0);
        check32({name, "_idle_after"}, {31'd0, busy}, 32'd0);
        check32({name, "_pending"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        int   lat;
        logic ill, aln;

        //          cls    rd     rs1    rs2    f3    f7    imm            word           ill   aln
        vecs[0]  = '{4'd0,  5'd3,  5'd1,  5'd2,  3'd0, 1'b0, 32'h0000_0000, 32'h002081B3, 1'b0, 1'b0};
        vecs[1]  = '{4'd1,  5'd1,  5'd0,  5'd0,  3'd0, 1'b0, 32'h0000_0005, 32'h00500093, 1'b0, 1'b0};
        vecs[2]  = '{4'd2,  5'd1,  5'd1,  5'd0,  3'd5, 1'b1, 32'h0000_0003, 32'h4030D093, 1'b0, 1'b0};
        vecs[3]  = '{4'd4,  5'd31, 5'd1,  5'd2,  3'd2, 1'b0, 32'h0000_0008, 32'h0020A423, 1'b0, 1'b0};
        vecs[4]  = '{4'd8,  5'd5,  5'd31, 5'd31, 3'd7, 1'b1, 32'h0001_2345, 32'h123452B7, 1'b0, 1'b0};
        vecs[5]  = '{4'd5,  5'd31, 5'd1,  5'd2,  3'd0, 1'b0, 32'h0000_0007, 32'h00208363, 1'b0, 1'b1};
        vecs[6]  = '{4'd6,  5'd1,  5'd7,  5'd9,  3'd3, 1'b1, 32'h0000_0800, 32'h001000EF, 1'b0, 1'b0};
        vecs[7]  = '{4'd9,  5'd10, 5'd0,  5'd0,  3'd0, 1'b0, 32'h000F_FFFF, 32'hFFFFF517, 1'b0, 1'b0};
        vecs[8]  = '{4'd3,  5'd4,  5'd2,  5'd0,  3'd2, 1'b0, 32'hFFFF_FFFC, 32'hFFC12203, 1'b0, 1'b0};
        vecs[9]  = '{4'd7,  5'd0,  5'd1,  5'd0,  3'd0, 1'b0, 32'h0000_0000, 32'h00008067, 1'b0, 1'b0};
        vecs[10] = '{4'd0,  5'd5,  5'd6,  5'd7,  3'd0, 1'b1, 32'h0000_0000, 32'h407302B3, 1'b0, 1'b0};
        vecs[11] = '{4'd12, 5'd1,  5'd1,  5'd1,  3'd0, 1'b0, 32'h0000_0000, 32'h00000000, 1'b1, 1'b0};
        vecs[12] = '{4'd5,  5'd0,  5'd3,  5'd4,  3'd1, 1'b0, 32'hFFFF_FFF8, 32'hFE419CE3, 1'b0, 1'b0};
        vecs[13] = '{4'd6,  5'd1,  5'd0,  5'd0,  3'd0, 1'b0, 32'h0000_0801, 32'h001000EF, 1'b0, 1'b1};
        vecs[14] = '{4'd1,  5'd1,  5'd1,  5'd0,  3'd0, 1'b0, 32'h1234_5FFF, 32'hFFF08093, 1'b0, 1'b0};
        vecs[15] = '{4'd2,  5'd2,  5'd3,  5'd31, 3'd5, 1'b0, 32'h0000_0FFF, 32'h01F1D113, 1'b0, 1'b0};

        // Reset state.
        #12;
        check32("reset_outputs",
                {in_ready, imem_we, busy, done, err_illegal, err_align}, 32'd0);
        check32("reset_addr", imem_addr, 32'd0);
        check32("reset_wdata", imem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Whole table as one session; base low bits must be ignored.
        open_session(32'h0000_0203, 16'd16);
        for (int i = 0; i < 16; i++) send(vecs[i]);
        wait_done("table", lat, ill, aln);
        check32("table_err_illegal", {31'd0, ill}, 32'd1);
        check32("table_err_align", {31'd0, aln}, 32'd1);

        // Single add at 0x100; done in the cycle after the accept.
        open_session(32'h0000_0100, 16'd1);
        send(vecs[0]);
        wait_done("single", lat, ill, aln);
        check32("single_done_latency", lat, 32'd0);
        check32("single_errs", {30'd0, ill, aln}, 32'd0);

        // Four back-to-back; a start pulse mid-session must be ignored.
        open_session(32'h0000_0100, 16'd4);
        send(vecs[1]);
        send(vecs[2]);
        start = 1'b1;
        base_addr = 32'hDEAD_0000;
        count = 16'd7;
        send(vecs[3]);
        start = 1'b0;
        send(vecs[4]);
        wait_done("stream", lat, ill, aln);
        check32("stream_throughput", last_wr - first_wr, 32'd3);
        check32("stream_errs", {30'd0, ill, aln}, 32'd0);

        // Illegal then addi: one write at base, err_illegal only.
        open_session(32'h0000_0100, 16'd2);
        send(vecs[11]);
        send(vecs[1]);
        wait_done("illegal", lat, ill, aln);
        check32("illegal_errs", {30'd0, ill, aln}, 32'd2);

        // Odd branch offset; err_illegal from the last session must be cleared.
        open_session(32'h0000_0100, 16'd1);
        send(vecs[5]);
        wait_done("align", lat, ill, aln);
        check32("align_errs", {30'd0, ill, aln}, 32'd1);

        // Empty session.
        open_session(32'h0000_0100, 16'd0);
        wait_done("empty", lat, ill, aln);
        check32("empty_done_latency", lat, 32'd0);

        // Reset in the middle of a four-instruction session.
        open_session(32'h0000_0400, 16'd4);
        send(vecs[0]);
        send(vecs[1]);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check32("abort_outputs",
                {in_ready, imem_we, busy, done, err_illegal, err_align}, 32'd0);
        check32("abort_addr", imem_addr, 32'd0);
        check32("abort_wdata", imem_wdata, 32'd0);
        check32("abort_pending", exp_q.size(), 32'd0);
        in_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check32("abort_idle", {30'd0, busy, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        open_session(32'h0000_0400, 16'd1);
        send(vecs[10]);
        wait_done("restart", lat, ill, aln);
        check32("restart_errs", {30'd0, ill, aln}, 32'd0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_encoder_loader.md
INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

Interface
REQ-001 Parameter CNT_W, default 16, width of the instruction-count field.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  one-cycle pulse that opens a load session.
REQ-005 base_addr  in  32  byte address of the first word; bits [1:0] ignored.
REQ-006 count  in  CNT_W  number of instructions in the session.
REQ-007 in_valid / in_ready  in / out  1 / 1  instruction-field handshake.
REQ-008 in_class  in  4  0=R, 1=I-arith, 2=I-shift, 3=load, 4=store, 5=branch, 6=jal, 7=jalr, 8=lui, 9=auipc; 10-15 illegal.
REQ-009 rd, rs1, rs2  in  5 each  register indices.
REQ-010 funct3  in  3; funct7b5  in  1 (instruction bit 30).
REQ-011 imm  in  32  signed immediate, or the upper 20-bit value for lui/auipc.
REQ-012 imem_we  out  1; imem_addr  out  32; imem_wdata  out  32  instruction-memory write port.
REQ-013 busy  out  1; done  out  1 (one-cycle pulse); err_illegal  out  1; err_align  out  1 (sticky).

Function
REQ-014 The FSM SHALL have three states: IDLE, LOAD and DONE.
REQ-015 In IDLE, start SHALL latch base_addr and count, clear both error flags, and go to LOAD, or go to DONE if count==0.
REQ-016 in_ready SHALL be 1 only in LOAD. start SHALL be ignored in LOAD and DONE.
REQ-017 An accept (in_valid & in_ready) SHALL decrement the remaining count. The accept that brings it to 0 SHALL move the FSM to DONE on the next edge.
REQ-018 DONE SHALL last exactly 1 cycle with done=1, then return to IDLE. busy SHALL be 1 in LOAD and DONE.
REQ-019 Throughput SHALL be 1 instruction per cycle. imem_we/addr/wdata SHALL be registered and assert in the cycle after the accept.
REQ-020 The write address SHALL start at {base_addr[31:2],2'b00} and advance by 4 after each write. It SHALL wrap modulo 2^32.
REQ-021 Opcodes per class: R 0110011; I-arith/I-shift 0010011; load 0000011; store 0100011; branch 1100011; jal 1101111; jalr 1100111; lui 0110111; auipc 0010111.
REQ-022 Encoding rules by class:
- R: funct7 = {0,funct7b5,00000}.
- I-arith, load, jalr: imm[11:0] in bits [31:20].
- I-shift: bits [31:25] = {0,funct7b5,00000}; imm[4:0] in bits [24:20].
- store: S layout.
- branch: B layout from imm[12:1].
- jal: J layout from imm[20:1].
- lui/auipc: imm[19:0] in bits [31:12].
REQ-023 funct3 SHALL be placed in bits [14:12] for classes that use it. Field bits a class does not use SHALL be 0.
REQ-024 An illegal class SHALL still be accepted and counted. It SHALL NOT be written, SHALL NOT advance the address, and SHALL set err_illegal.
REQ-025 For branch or jal with imm[0]=1, the encoder SHALL write the word (imm[0] dropped) and set err_align.
REQ-026 Immediate bits above the field width SHALL be truncated silently.

Reset
REQ-027 When rst_n=0, the block SHALL asynchronously force:
- state IDLE;
- in_ready, imem_we, busy, done, err_illegal and err_align to 0;
- imem_addr, imem_wdata, the remaining count and the address counter to 0.
REQ-028 A reset during LOAD SHALL abort the session. No write SHALL occur after rst_n deasserts until a new start.

Structure
REQ-029 The class codes, the opcode constants and the FSM state encoding SHALL live in a shared package, rv_isa_pkg.
REQ-030 Field packing SHALL be one combinational sub-module, rv_field_packer (class + fields -> 32-bit word + illegal flag). The FSM, counters and output register stay in the top.

Verification
REQ-031 start base=0x100, count=1; R add rd=3 rs1=1 rs2=2 -> one imem_we at addr 0x100, wdata 0x002081B3, done one cycle later.
REQ-032 count=4 streamed back-to-back: addi x1,x0,5; srai x1,x1,3; sw x2,8(x1); lui x5,0x12345 -> wdata 0x00500093, 0x4030D093, 0x0020A423, 0x123452B7 at 0x100/104/108/10C, one per cycle.
REQ-033 count=2; class 12 then addi -> err_illegal=1; one write only, at base; done asserted.
REQ-034 branch with imm=0x7 -> err_align=1; word encoded with imm 0x6.
REQ-035 start with count=0 -> done after 1 cycle, no imem_we.
REQ-036 rst_n low after 2 of 4 accepts -> all outputs 0 at once; no further writes; the next start from base_addr works normally.
